// File: rtl/usb_rx_nrzi_unstuff_if.sv
// Bit-level receive handshake: line samples from clock recovery going in,
// SIPO shift pair and packet-layer status flags coming out.
interface usb_rx_nrzi_unstuff_if;
    logic sample_en;
    logic dp;
    logic dm;
    logic shift_enable;
    logic serial_in;
    logic rx_active;
    logic eop;
    logic stuff_err;
    logic rx_err;

    // Upstream side: drives line samples, observes decoded output
    modport master (
        output sample_en, dp, dm,
        input  shift_enable, serial_in, rx_active, eop, stuff_err, rx_err
    );

    // Decoder side: consumes line samples, drives the SIPO and status flags
    modport slave (
        input  sample_en, dp, dm,
        output shift_enable, serial_in, rx_active, eop, stuff_err, rx_err
    );
endinterface

// File: rtl/usb_rx_nrzi_unstuff.sv
// USB receive front end: NRZI decode, SYNC/EOP detection and bit destuffing.
// Every output is registered; the effect of a sample appears one clock after
// the sample_en cycle that carried it.
module usb_rx_nrzi_unstuff #(
    parameter int SYNC_MIN_ZEROS = 5,
    parameter bit LOW_SPEED      = 1'b0,
    parameter int IDLE_J_COUNT   = 8
) (
    input logic                   CLK,
    input logic                   nRST,
    usb_rx_nrzi_unstuff_if.slave  bus
);

    localparam int         JCW      = (IDLE_J_COUNT < 2) ? 1 : $clog2(IDLE_J_COUNT);
    localparam logic [2:0] SYNC_MIN = 3'(SYNC_MIN_ZEROS);
    localparam logic [JCW-1:0] J_LAST = JCW'(IDLE_J_COUNT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP,
        ST_ERROR
    } state_t;

    state_t state_q, state_d;

    logic           prev_j_q, prev_j_d;     // last J/K state seen was J
    logic [2:0]     zero_cnt_q, zero_cnt_d;
    logic [2:0]     ones_cnt_q, ones_cnt_d;
    logic [2:0]     byte_cnt_q, byte_cnt_d;
    logic [JCW-1:0] j_cnt_q, j_cnt_d;       // consecutive J samples while in ERROR
    logic           last_se0_q, last_se0_d; // previous sample was SE0

    logic shift_p1, shift_d;
    logic serial_p1, serial_d;
    logic active_p1, active_d;
    logic eop_p1, eop_d;
    logic stuff_err_p1, stuff_err_d;
    logic rx_err_p1, rx_err_d;

    logic line_j, line_k, line_se0, line_se1, line_jk, dec_bit;

    // Low speed swaps which differential state is J
    assign line_j   = LOW_SPEED ? (~bus.dp &  bus.dm) : ( bus.dp & ~bus.dm);
    assign line_k   = LOW_SPEED ? ( bus.dp & ~bus.dm) : (~bus.dp &  bus.dm);
    assign line_se0 = ~bus.dp & ~bus.dm;
    assign line_se1 =  bus.dp &  bus.dm;
    assign line_jk  = line_j | line_k;
    // NRZI: no transition decodes as 1
    assign dec_bit  = (line_j == prev_j_q);

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic, advanced only on bit-centre strobes
    always_comb begin
        state_d = state_q;
        if (bus.sample_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (line_k) state_d = ST_SYNC;
                end
                ST_SYNC: begin
                    if (!line_jk)     state_d = ST_IDLE;
                    else if (dec_bit) state_d = (zero_cnt_q >= SYNC_MIN) ? ST_DATA : ST_IDLE;
                end
                ST_DATA: begin
                    if (line_se0)                              state_d = ST_EOP;
                    else if (line_se1)                         state_d = ST_ERROR;
                    else if (ones_cnt_q == 3'd6 && dec_bit)    state_d = ST_ERROR;
                end
                ST_EOP: begin
                    if (line_j)        state_d = ST_IDLE;
                    else if (!line_se0) state_d = ST_ERROR;
                end
                ST_ERROR: begin
                    if (line_j && (last_se0_q || j_cnt_q == J_LAST)) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output and counter next values; pulses default low so they last one clock
    always_comb begin
        prev_j_d    = prev_j_q;
        zero_cnt_d  = zero_cnt_q;
        ones_cnt_d  = ones_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        j_cnt_d     = j_cnt_q;
        last_se0_d  = last_se0_q;
        shift_d     = 1'b0;
        serial_d    = serial_p1;
        active_d    = active_p1;
        eop_d       = 1'b0;
        stuff_err_d = 1'b0;
        rx_err_d    = 1'b0;
        if (bus.sample_en) begin
            if (line_jk) prev_j_d = line_j;
            last_se0_d = line_se0;
            j_cnt_d    = '0;
            case (state_q)
                ST_IDLE: begin
                    if (line_k) zero_cnt_d = 3'd1;
                end
                ST_SYNC: begin
                    if (line_jk && !dec_bit && zero_cnt_q != 3'd7)
                        zero_cnt_d = zero_cnt_q + 3'd1;
                    // SYNC's closing 1 already counts toward the six-ones run
                    if (line_jk && dec_bit && zero_cnt_q >= SYNC_MIN) begin
                        active_d   = 1'b1;
                        ones_cnt_d = 3'd1;
                        byte_cnt_d = 3'd0;
                    end
                end
                ST_DATA: begin
                    if (line_jk) begin
                        if (ones_cnt_q == 3'd6) begin
                            if (!dec_bit) begin
                                ones_cnt_d = 3'd0;
                            end else begin
                                stuff_err_d = 1'b1;
                                active_d    = 1'b0;
                            end
                        end else begin
                            shift_d    = 1'b1;
                            serial_d   = dec_bit;
                            byte_cnt_d = byte_cnt_q + 3'd1;
                            ones_cnt_d = dec_bit ? ones_cnt_q + 3'd1 : 3'd0;
                        end
                    end else if (line_se1) begin
                        rx_err_d = 1'b1;
                        active_d = 1'b0;
                    end
                end
                ST_EOP: begin
                    if (line_j) begin
                        eop_d    = (byte_cnt_q == 3'd0);
                        rx_err_d = (byte_cnt_q != 3'd0);
                        active_d = 1'b0;
                    end else if (!line_se0) begin
                        rx_err_d = 1'b1;
                        active_d = 1'b0;
                    end
                end
                ST_ERROR: begin
                    if (line_j && j_cnt_q != J_LAST) j_cnt_d = j_cnt_q + JCW'(1);
                end
                default: ;
            endcase
        end
    end

    // Counter and output registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            prev_j_q     <= 1'b1;
            zero_cnt_q   <= '0;
            ones_cnt_q   <= '0;
            byte_cnt_q   <= '0;
            j_cnt_q      <= '0;
            last_se0_q   <= 1'b0;
            shift_p1     <= 1'b0;
            serial_p1    <= 1'b0;
            active_p1    <= 1'b0;
            eop_p1       <= 1'b0;
            stuff_err_p1 <= 1'b0;
            rx_err_p1    <= 1'b0;
        end else begin
            prev_j_q     <= prev_j_d;
            zero_cnt_q   <= zero_cnt_d;
            ones_cnt_q   <= ones_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            j_cnt_q      <= j_cnt_d;
            last_se0_q   <= last_se0_d;
            shift_p1     <= shift_d;
            serial_p1    <= serial_d;
            active_p1    <= active_d;
            eop_p1       <= eop_d;
            stuff_err_p1 <= stuff_err_d;
            rx_err_p1    <= rx_err_d;
        end
    end

    assign bus.shift_enable = shift_p1;
    assign bus.serial_in    = serial_p1;
    assign bus.rx_active    = active_p1;
    assign bus.eop          = eop_p1;
    assign bus.stuff_err    = stuff_err_p1;
    assign bus.rx_err       = rx_err_p1;

endmodule

// File: tb/tb_usb_rx_nrzi_unstuff.sv
// Bench for usb_rx_nrzi_unstuff: line-state vector tables with hand-written
// expected outputs, fed through a scoreboard queue to a monitor process.
module tb_usb_rx_nrzi_unstuff;

    localparam logic [1:0] LJ = 2'b10;
    localparam logic [1:0] LK = 2'b01;
    localparam logic [1:0] L0 = 2'b00;
    localparam logic [1:0] L1 = 2'b11;

    typedef struct {
        int         id;
        logic [1:0] ln;   // {dp, dm}
        logic       sh;
        logic       si;
        logic       act;
        logic       ep;
        logic       se;
        logic       re;
    } vec_t;

    logic CLK = 1'b0;
    logic nRST = 1'b0;

    usb_rx_nrzi_unstuff_if bus ();

    usb_rx_nrzi_unstuff #(
        .SYNC_MIN_ZEROS (5),
        .LOW_SPEED      (1'b0),
        .IDLE_J_COUNT   (8)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    vec_t tbl[$];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;
    logic tb_prev_j = 1'b1;
    logic exp_act_hold = 1'b0;
    logic exp_si_hold = 1'b0;

    vec_t       mon_e;
    logic [5:0] mon_got;
    logic [5:0] mon_exp;
    logic [5:0] rst_got;

    // Line state that carries decoded bit b after the last queued J/K
    function automatic logic [1:0] nz(input logic b);
        return ((b == 1'b1) == tb_prev_j) ? LJ : LK;
    endfunction

    task automatic add(input logic [1:0] ln, input logic sh, input logic si, input logic act,
                       input logic ep, input logic se, input logic re);
        vec_t v;
        v.id = vec_id; v.ln = ln; v.sh = sh; v.si = si;
        v.act = act; v.ep = ep; v.se = se; v.re = re;
        vec_id++;
        tbl.push_back(v);
        if (ln == LJ) tb_prev_j = 1'b1;
        else if (ln == LK) tb_prev_j = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) add(LJ, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic quiet(input logic [1:0] ln);
        add(ln, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic sync_pat();
        for (int i = 0; i < 7; i++) add(nz(0), 0, 0, 0, 0, 0, 0);
        add(nz(1), 0, 0, 1, 0, 0, 0);
    endtask

    task automatic bit_ok(input logic b);
        add(nz(b), 1, b, 1, 0, 0, 0);
    endtask

    task automatic bits8(input logic [7:0] b);
        for (int i = 0; i < 8; i++) bit_ok(b[i]);
    endtask

    task automatic eop_ok();
        add(L0, 0, 0, 1, 0, 0, 0);
        add(L0, 0, 0, 1, 0, 0, 0);
        add(LJ, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic play();
        foreach (tbl[i]) begin
            @(negedge CLK);
            bus.dp = tbl[i].ln[1];
            bus.dm = tbl[i].ln[0];
            bus.sample_en = 1'b1;
            sb.push_back(tbl[i]);
            @(negedge CLK);
            bus.sample_en = 1'b0;
        end
        tbl.delete();
        @(negedge CLK);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d vectors left unchecked, required 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: compare one record per strobe, and hold/clear behaviour between strobes
    initial begin
        forever begin
            @(posedge CLK);
            if (nRST) begin
                if (bus.sample_en) begin
                    #1;
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL sb_underflow: output with no queued expectation");
                    end else begin
                        mon_e = sb.pop_front();
                        mon_got = {bus.shift_enable, bus.serial_in, bus.rx_active,
                                   bus.eop, bus.stuff_err, bus.rx_err};
                        mon_exp = {mon_e.sh, mon_e.sh ? mon_e.si : exp_si_hold, mon_e.act,
                                   mon_e.ep, mon_e.se, mon_e.re};
                        if (mon_got !== mon_exp) begin
                            errors++;
                            $display("FAIL vec%0d sh/si/act/eop/stf/err got=%b required=%b",
                                     mon_e.id, mon_got, mon_exp);
                        end
                        exp_act_hold = mon_e.act;
                        if (mon_e.sh) exp_si_hold = mon_e.si;
                    end
                end else begin
                    #1;
                    checks++;
                    mon_got = {bus.shift_enable, bus.serial_in, bus.rx_active,
                               bus.eop, bus.stuff_err, bus.rx_err};
                    mon_exp = {1'b0, exp_si_hold, exp_act_hold, 3'b000};
                    if (mon_got !== mon_exp) begin
                        errors++;
                        $display("FAIL gap sh/si/act/eop/stf/err got=%b required=%b",
                                 mon_got, mon_exp);
                    end
                end
            end
        end
    end

    initial begin
        bus.sample_en = 1'b0;
        bus.dp = 1'b1;
        bus.dm = 1'b0;

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        rst_got = {bus.shift_enable, bus.serial_in, bus.rx_active,
                   bus.eop, bus.stuff_err, bus.rx_err};
        if (rst_got !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b required=000000", rst_got);
        end
        @(negedge CLK);
        nRST = 1'b1;

        // Basic packet, with SE1 ignored while idle
        idle(2); quiet(L1); idle(1);
        sync_pat(); bits8(8'b1010_0101); eop_ok(); idle(2);
        play();

        // Destuffing: five 1s after SYNC's 1, stuffed 0 dropped, three more 1s
        idle(1); sync_pat();
        for (int i = 0; i < 5; i++) bit_ok(1);
        add(nz(0), 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) bit_ok(1);
        eop_ok(); idle(1);
        play();

        // Stuff violation, ERROR ignores K/J until SE0 then J, then a clean packet
        idle(1); sync_pat();
        for (int i = 0; i < 5; i++) bit_ok(1);
        add(nz(1), 0, 0, 0, 0, 1, 0);
        quiet(LK); quiet(LJ); quiet(LK); quiet(LJ); quiet(L0); quiet(LJ);
        idle(1); sync_pat(); bits8(8'b0001_0110); eop_ok(); idle(1);
        play();

        // Short SYNC: 3 and 4 zeros rejected, 5 zeros accepted; empty packet ends aligned
        idle(1);
        quiet(nz(0)); quiet(nz(0)); quiet(nz(0)); quiet(nz(1));
        idle(1);
        quiet(nz(0)); quiet(nz(0)); quiet(nz(0)); quiet(nz(0)); quiet(nz(1));
        idle(1);
        for (int i = 0; i < 5; i++) quiet(nz(0));
        add(nz(1), 0, 0, 1, 0, 0, 0);
        eop_ok(); idle(1);
        play();

        // Misaligned EOP after 5 payload bits
        idle(1); sync_pat();
        bit_ok(1); bit_ok(0); bit_ok(1); bit_ok(0); bit_ok(0);
        add(L0, 0, 0, 1, 0, 0, 0);
        add(LJ, 0, 0, 0, 0, 0, 1);
        idle(1);
        play();

        // SE1 in DATA; 7 Js are not enough, a SYNC pattern in ERROR is ignored; 8 Js release
        idle(1); sync_pat(); bit_ok(0); bit_ok(1);
        add(L1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 7; i++) quiet(LJ);
        for (int i = 0; i < 7; i++) quiet(nz(0));
        quiet(nz(1));
        for (int i = 0; i < 8; i++) quiet(LJ);
        sync_pat(); bits8(8'b0001_0110); eop_ok(); idle(1);
        play();

        // K after SE0 in EOP, then SE0,J recovery and an empty packet
        idle(1); sync_pat(); bits8(8'b0111_0011);
        add(L0, 0, 0, 1, 0, 0, 0);
        add(LK, 0, 0, 0, 0, 0, 1);
        quiet(L0); quiet(LJ); idle(1);
        sync_pat(); eop_ok(); idle(1);
        play();

        // Reset mid-packet after 3 payload bits
        idle(1); sync_pat(); bit_ok(1); bit_ok(0); bit_ok(1);
        play();
        @(negedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        checks++;
        rst_got = {bus.shift_enable, bus.serial_in, bus.rx_active,
                   bus.eop, bus.stuff_err, bus.rx_err};
        if (rst_got !== 6'b0) begin
            errors++;
            $display("FAIL midpacket_reset got=%b required=000000", rst_got);
        end
        exp_act_hold = 1'b0;
        exp_si_hold = 1'b0;
        tb_prev_j = 1'b1;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        idle(2); sync_pat(); bits8(8'b1010_0101); eop_ok(); idle(1);
        play();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_rx_nrzi_unstuff.md
Name: usb_rx_nrzi_unstuff

Overview:
- Receive-path bit-level front end. Sits directly upstream of the receive SIPO shift register.
- Takes synchronized D+/D- line samples, qualified by a bit-centre strobe from clock recovery.
- Decodes NRZI, detects SYNC and EOP, and removes stuffed bits.
- Drives the SIPO's shift_enable/serial_in pair with exactly one pulse per real payload bit, in line order.
- Flags stuffing and line-state errors to the packet layer.

Parameters:
- SYNC_MIN_ZEROS, 5, minimum decoded zeros before the SYNC-terminating 1 for the SYNC to be accepted (range 1..7).
- LOW_SPEED, 0, 1 swaps J/K polarity (low-speed: J = D- high).
- IDLE_J_COUNT, 8, consecutive J samples that release the ERROR state.

Ports:
- CLK  input  1  system clock
- nRST  input  1  asynchronous active-low reset
- sample_en  input  1  one-cycle strobe at bit centre; all state advances only on cycles where it is high
- dp  input  1  synchronized D+
- dm  input  1  synchronized D-
- shift_enable  output  1  one-cycle pulse: serial_in carries one payload bit
- serial_in  output  1  decoded, unstuffed payload bit; valid while shift_enable is high, otherwise holds last value
- rx_active  output  1  high from SYNC acceptance to EOP or error
- eop  output  1  one-cycle pulse on valid end of packet
- stuff_err  output  1  one-cycle pulse on bit-stuff violation
- rx_err  output  1  one-cycle pulse on SE1, K after SE0, or non-byte-aligned EOP

Behaviour:
- Reset: all outputs 0; state IDLE; previous line state J; all counters 0. Asynchronous, valid at any point including mid-packet.
- Line states (LOW_SPEED=0):
  - J = dp1/dm0
  - K = dp0/dm1
  - SE0 = 00
  - SE1 = 11
- NRZI decode:
  - Decoded bit = 1 if the J/K state equals the previous J/K sample, 0 on a transition.
  - SE0/SE1 samples do not update the previous state.
- Timing: all outputs are registered and assert in the cycle after the sample_en cycle that caused them. Latency 1 clock.
- ones_cnt (3 bits) counts consecutive decoded 1s for destuffing.
- byte_cnt (3 bits) counts emitted payload bits modulo 8.
- FSM states: IDLE, SYNC, DATA, EOP, ERROR. Transitions (taken only on sample_en):
  - IDLE:
    - K -> SYNC, zero_cnt=1.
    - J/SE0 stay.
    - SE1 stay, no error flagged.
  - SYNC:
    - Decoded 0 -> zero_cnt++, saturating at 7.
    - Decoded 1 with zero_cnt >= SYNC_MIN_ZEROS -> DATA: rx_active=1, ones_cnt=1 (the SYNC's final 1 counts toward stuffing), byte_cnt=0.
    - Decoded 1 with zero_cnt < SYNC_MIN_ZEROS -> IDLE silently.
    - SE0/SE1 -> IDLE silently.
  - DATA, J/K sample:
    - If ones_cnt==6 and decoded 0: stuffed bit. Drop it (no shift_enable), ones_cnt=0.
    - If ones_cnt==6 and decoded 1: stuff_err pulse, rx_active=0 -> ERROR, no shift.
    - Otherwise: shift_enable pulse with serial_in=decoded bit, byte_cnt++. ones_cnt++ on 1, cleared on 0.
  - DATA, other line states:
    - SE0 -> EOP.
    - SE1 -> rx_err pulse, rx_active=0 -> ERROR.
  - EOP:
    - SE0 stays in EOP.
    - J: if byte_cnt==0, eop pulse; else rx_err pulse (misaligned). Either way rx_active=0 -> IDLE, prev state=J.
    - K or SE1 -> rx_err pulse, rx_active=0 -> ERROR.
  - ERROR:
    - J following an SE0 sample -> IDLE.
    - IDLE_J_COUNT consecutive J samples -> IDLE.
    - No outputs are asserted while in ERROR.
- Simultaneous events: at most one of eop/stuff_err/rx_err pulses per cycle. shift_enable is never asserted in the same cycle as any of them.
- sample_en low: no state, counter, or output change except clearing pulses.

Test Plan:
- Basic packet: J idle, then KJKJKJKK, then decoded bits 1,0,1,0,0,1,0,1, SE0, SE0, J -> rx_active rises 1 clk after the final K; exactly 8 shift_enable pulses with serial_in 1,0,1,0,0,1,0,1; eop pulse 1 clk after J; rx_active falls with eop.
- Destuff: SYNC then decoded 1,1,1,1,1,0,1,1,1 (0 is the stuffed bit after 6 ones including SYNC's 1) -> 8 shift pulses, all serial_in=1; the 0 is not emitted; no errors.
- Stuff violation: SYNC then six decoded 1s -> 5 shifts; 6th 1 gives stuff_err pulse, rx_active=0, no shift; subsequent K/J ignored until SE0,J -> back to IDLE, next valid packet received normally.
- Short SYNC: J, K, J, K, K (3 zeros, SYNC_MIN_ZEROS=5) -> no rx_active, no pulses; with zeros=5 (KJKJKK) -> rx_active asserted.
- Misaligned/illegal EOP: SYNC, 5 payload bits, SE0, J -> rx_err pulse, no eop. Separately SE1 during DATA -> rx_err pulse, ERROR; 8 J samples -> IDLE.
- Reset mid-packet: nRST low after 3 payload bits -> all outputs 0 immediately; after release, J idle plus a full packet decodes correctly.
